// File: rtl/flags_unit.sv
// flags_unit: computes and registers N/Z/C/V from ALU operations.
// Includes a small LIFO shadow stack used to save/restore flags.
module flags_unit #(
   parameter int STACK_DEPTH = 2,
   parameter int WIDTH       = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               upd_valid,
   output logic                               upd_ready,
   input  logic [2:0]                         op,
   input  logic [WIDTH-1:0]                   operand_a,
   input  logic [WIDTH-1:0]                   operand_b,
   input  logic [WIDTH-1:0]                   logic_result,
   input  logic                               shift_carry,
   input  logic [3:0]                         write_mask,
   input  logic                               save,
   input  logic                               restore,
   output logic [3:0]                         flags,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
   output logic                               stack_error
);

   localparam int CW = $clog2(STACK_DEPTH + 1);
   localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_ADC   = 3'b001;
   localparam logic [2:0] OP_SUB   = 3'b010;
   localparam logic [2:0] OP_SBC   = 3'b011;
   localparam logic [2:0] OP_LOGIC = 3'b100;
   localparam logic [2:0] OP_LOAD  = 3'b101;

   // flags layout: {N, Z, C, V}
   logic [3:0]       r_flags;
   logic [CW-1:0]    r_count;
   logic             r_err;
   logic [3:0]       r_stack [STACK_DEPTH];

   logic             w_acc;
   logic [WIDTH-1:0] w_b;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic             w_v;
   logic [3:0]       w_calc;
   logic [3:0]       w_upd;
   logic             w_save_only;
   logic             w_rest_only;
   logic             w_conflict;
   logic             w_can_push;
   logic             w_can_pop;
   logic [IW-1:0]    w_push_idx;
   logic [IW-1:0]    w_pop_idx;

   // An update colliding with a restore is held off; the producer retries.
   assign upd_ready = ~restore;
   assign w_acc     = upd_valid & upd_ready;

   // Subtract forms invert b; carry-in is 0/1 for ADD/SUB, flags.C otherwise.
   assign w_b   = op[1] ? ~operand_b : operand_b;
   assign w_cin = op[0] ? r_flags[1] : op[1];
   assign w_sum = {1'b0, operand_a} + {1'b0, w_b}
                + {{WIDTH{1'b0}}, w_cin};

   // Overflow on the effective operands covers both add and subtract.
   assign w_v = (operand_a[WIDTH-1] == w_b[WIDTH-1])
             && (w_sum[WIDTH-1] != operand_a[WIDTH-1]);

   // Candidate flag values for the requested op (reserved ops keep old).
   always_comb begin
      w_calc = r_flags;
      unique case (op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            w_calc = {w_sum[WIDTH-1],
                      (w_sum[WIDTH-1:0] == '0),
                      w_sum[WIDTH],
                      w_v};
         end
         OP_LOGIC: begin
            w_calc = {logic_result[WIDTH-1],
                      (logic_result == '0),
                      shift_carry,
                      r_flags[0]};
         end
         OP_LOAD: begin
            w_calc = operand_a[WIDTH-1:WIDTH-4];
         end
         default: begin
            w_calc = r_flags;
         end
      endcase
   end

   assign w_upd = (write_mask & w_calc) | (~write_mask & r_flags);

   assign w_save_only = save & ~restore;
   assign w_rest_only = restore & ~save;
   assign w_conflict  = save & restore;
   assign w_can_push  = (r_count < CW'(STACK_DEPTH));
   assign w_can_pop   = (r_count != '0);
   assign w_push_idx  = IW'(r_count);
   assign w_pop_idx   = IW'(r_count - 1'b1);

   // Flags, stack depth and sticky error; restore wins over updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags <= 4'b0000;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_rest_only && w_can_pop) begin
            r_flags <= r_stack[w_pop_idx];
         end else if (w_acc) begin
            r_flags <= w_upd;
         end
         if (w_save_only && w_can_push) begin
            r_count <= r_count + 1'b1;
         end else if (w_rest_only && w_can_pop) begin
            r_count <= r_count - 1'b1;
         end
         if ((w_save_only && !w_can_push)
             || (w_rest_only && !w_can_pop)
             || w_conflict) begin
            r_err <= 1'b1;
         end
      end
   end

   // Stack storage captures the pre-update flags; contents need no reset.
   always_ff @(posedge clk) begin
      if (!rst && w_save_only && w_can_push) begin
         r_stack[w_push_idx] <= r_flags;
      end
   end

   assign flags       = r_flags;
   assign stack_count = r_count;
   assign stack_error = r_err;

endmodule
